// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receive FIFO and its producer/consumer (rx core, APB regs).
// The slave modport is the FIFO side; the master modport is the side that drives it.
interface uart_rx_fifo_if #(
    parameter int unsigned AW = 4
);
    // Receiver core side
    logic          baudx16;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;

    // APB register side
    logic          rd_en;
    logic          flush;
    logic          ovr_clr;
    logic          irq_en;
    logic [7:0]    rd_data;
    logic          rd_err;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          timeout;
    logic          irq;

    modport master (
        output baudx16, rx_data, rx_valid, rx_ferr,
        output rd_en, flush, ovr_clr, irq_en,
        input  rd_data, rd_err, empty, full, count, overrun, timeout, irq
    );

    modport slave (
        input  baudx16, rx_data, rx_valid, rx_ferr,
        input  rd_en, flush, ovr_clr, irq_en,
        output rd_data, rd_err, empty, full, count, overrun, timeout, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO (first-word-fall-through) with threshold, idle-timeout and overrun irq.
// Define RXFIFO_FERR_TAG_EN to store each byte's framing-error flag and expose it on rd_err.
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned THRESH   = 4,
    parameter int unsigned TO_TICKS = 640
) (
    input logic           pclk,
    input logic           prstn,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned TW = $clog2(TO_TICKS + 1);
`ifdef RXFIFO_FERR_TAG_EN
    localparam int unsigned EW = 9;
`else
    localparam int unsigned EW = 8;
`endif
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   THR_CNT  = (AW + 1)'(THRESH);
    localparam logic [TW-1:0] TO_MAX   = TW'(TO_TICKS);

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          irq_q, irq_d;

    logic          empty, full, pop, push, drop, activity;
    logic [EW-1:0] wr_entry, head;

`ifdef RXFIFO_FERR_TAG_EN
    assign wr_entry = {bus.rx_ferr, bus.rx_data};
`else
    logic unused_ferr;
    assign unused_ferr = bus.rx_ferr;
    assign wr_entry    = bus.rx_data;
`endif

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        pop   = bus.rd_en && !empty;
        // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
        push  = bus.rx_valid && (!full || pop);
        drop  = bus.rx_valid && !push;
        activity = bus.flush || push || pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        overrun_d = bus.ovr_clr ? 1'b0 : (overrun_q || drop);

        to_cnt_d = to_cnt_q;
        if (activity || empty) begin
            to_cnt_d = '0;
        end else if (bus.baudx16 && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        timeout_d = !activity && !empty && (to_cnt_q == TO_MAX);
        irq_d     = bus.irq_en && ((count_q >= THR_CNT) || timeout_q || overrun_q);
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            to_cnt_q  <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            to_cnt_q  <= to_cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge pclk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign head = mem[rd_ptr_q];

    always_comb begin
        bus.rd_data = empty ? 8'h00 : head[7:0];
`ifdef RXFIFO_FERR_TAG_EN
        bus.rd_err  = empty ? 1'b0 : head[8];
`else
        bus.rd_err  = 1'b0;
`endif
    end

    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;
    assign bus.timeout = timeout_q;
    assign bus.irq     = irq_q;

endmodule
